// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : ID->EX issue stage for the 16-bit MIPS-style core. Decodes the
//            instruction into an alu_16b control code, formats the operands
//            (sign/zero extension, shift amount placed in opB[10:6]), and
//            presents the result through a registered output stage backed by
//            a single skid entry. Valid/ready handshakes on both sides; a
//            flush from branch logic drops everything buffered.
// Ports    : clk, rst (sync, active-high), flush
//            in_valid/in_ready, instr[15:0], rs_data[31:0], rt_data[31:0]
//            out_valid/out_ready, alu_ctrl[3:0], opA[31:0], opB[31:0],
//            dest_reg[2:0], wb_en, illegal (sticky), issue_cnt[CNT_W-1:0]
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instr,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_ctrl,
    output logic [31:0]      opA,
    output logic [31:0]      opB,
    output logic [2:0]       dest_reg,
    output logic             wb_en,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_cnt
);

    // Payload layout: {alu_ctrl, opA, opB, dest_reg, wb_en}
    localparam int c_PW = 4 + 32 + 32 + 3 + 1;

    localparam logic [3:0] c_ALU_NOP  = 4'b0000;
    localparam logic [3:0] c_ALU_ADD  = 4'b0001;
    localparam logic [3:0] c_ALU_SUB  = 4'b1001;
    localparam logic [3:0] c_ALU_AND  = 4'b0011;
    localparam logic [3:0] c_ALU_OR   = 4'b0100;
    localparam logic [3:0] c_ALU_SLL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRL  = 4'b1101;
    localparam logic [3:0] c_ALU_LUI  = 4'b0111;
    localparam logic [3:0] c_ALU_SLT  = 4'b0010;
    localparam logic [3:0] c_ALU_SLTU = 4'b1010;

    logic [3:0]      w_op;
    logic [2:0]      w_funct;
    logic [5:0]      w_imm6;
    logic [8:0]      w_imm9;
    logic [31:0]     w_sext6;
    logic [31:0]     w_zext6;

    logic [3:0]      w_ctrl;
    logic [31:0]     w_opa;
    logic [31:0]     w_opb;
    logic [2:0]      w_dest;
    logic            w_illegal;
    logic [c_PW-1:0] w_payload;

    logic            w_accept;
    logic            w_drain;
    logic            w_out_free;

    logic [c_PW-1:0]  r_out;
    logic             r_out_valid;
    logic [c_PW-1:0]  r_skid;
    logic             r_skid_valid;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    assign w_op    = instr[15:12];
    assign w_funct = instr[2:0];
    assign w_imm6  = instr[5:0];
    assign w_imm9  = instr[8:0];
    assign w_sext6 = {{26{w_imm6[5]}}, w_imm6};
    assign w_zext6 = {26'b0, w_imm6};

    always_comb begin
        w_ctrl    = c_ALU_NOP;
        w_opa     = 32'b0;
        w_opb     = 32'b0;
        w_dest    = 3'b0;
        w_illegal = 1'b0;
        case (w_op)
            4'b0000: begin
                w_opa  = rs_data;
                w_opb  = rt_data;
                w_dest = instr[5:3];
                case (w_funct)
                    3'b000:  w_ctrl = c_ALU_ADD;
                    3'b001:  w_ctrl = c_ALU_SUB;
                    3'b010:  w_ctrl = c_ALU_AND;
                    3'b011:  w_ctrl = c_ALU_OR;
                    3'b100:  w_ctrl = c_ALU_SLT;
                    3'b101:  w_ctrl = c_ALU_SLTU;
                    default: w_illegal = 1'b1;
                endcase
            end
            4'b0001: begin w_ctrl = c_ALU_ADD;  w_opa = rs_data; w_opb = w_sext6; w_dest = instr[8:6]; end
            4'b0010: begin w_ctrl = c_ALU_AND;  w_opa = rs_data; w_opb = w_zext6; w_dest = instr[8:6]; end
            4'b0011: begin w_ctrl = c_ALU_OR;   w_opa = rs_data; w_opb = w_zext6; w_dest = instr[8:6]; end
            4'b0100: begin w_ctrl = c_ALU_SLT;  w_opa = rs_data; w_opb = w_sext6; w_dest = instr[8:6]; end
            4'b0101: begin w_ctrl = c_ALU_SLTU; w_opa = rs_data; w_opb = w_sext6; w_dest = instr[8:6]; end
            4'b0110: begin
                w_ctrl = c_ALU_SLL; w_opa = rs_data; w_dest = instr[8:6];
                w_opb  = {21'b0, w_imm6[4:0], 6'b0};
            end
            4'b0111: begin
                w_ctrl = c_ALU_SRL; w_opa = rs_data; w_dest = instr[8:6];
                w_opb  = {21'b0, w_imm6[4:0], 6'b0};
            end
            4'b1000: begin w_ctrl = c_ALU_LUI; w_opb = {23'b0, w_imm9}; w_dest = instr[11:9]; end
            default: w_illegal = 1'b1;
        endcase
        // Illegal ops still flow downstream, but as an inert bubble.
        if (w_illegal) begin
            w_ctrl = c_ALU_NOP;
            w_opa  = 32'b0;
            w_opb  = 32'b0;
            w_dest = 3'b0;
        end
    end

    assign w_payload = {w_ctrl, w_opa, w_opb, w_dest, ~w_illegal};

    // in_ready is a pure register output: the skid must be empty.
    assign in_ready   = ~r_skid_valid;
    assign w_accept   = in_valid & ~r_skid_valid & ~flush;
    assign w_drain    = r_out_valid & out_ready;
    assign w_out_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_illegal    <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_drain) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
                r_illegal    <= 1'b0;
            end else begin
                if (w_accept && w_illegal) begin
                    r_illegal <= 1'b1;
                end
                if (w_out_free) begin
                    // Skid is older than anything arriving now; it goes first.
                    // A new accept cannot coincide with a full skid.
                    if (r_skid_valid) begin
                        r_out        <= r_skid;
                        r_out_valid  <= 1'b1;
                        r_skid_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_out       <= w_payload;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end else if (w_accept) begin
                    r_skid       <= w_payload;
                    r_skid_valid <= 1'b1;
                end
            end
        end
    end

    assign {alu_ctrl, opA, opB, dest_reg, wb_en} = r_out;
    assign out_valid = r_out_valid;
    assign illegal   = r_illegal;
    assign issue_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Self-checking bench for alu_issue_stage: decode vector table,
//            backpressure/skid ordering, illegal + flush, counter wrap with a
//            narrow counter instance, and reset during a stall.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [2:0]  dest_reg;
    logic        wb_en;
    logic        illegal;
    logic [15:0] issue_cnt;

    // Narrow-counter instance for the wrap check.
    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [3:0]  s_alu_ctrl;
    logic [31:0] s_opA;
    logic [31:0] s_opB;
    logic [2:0]  s_dest_reg;
    logic        s_wb_en;
    logic        s_illegal;
    logic [1:0]  s_issue_cnt;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .opA(opA), .opB(opB),
        .dest_reg(dest_reg), .wb_en(wb_en),
        .illegal(illegal), .issue_cnt(issue_cnt)
    );

    alu_issue_stage #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .instr(16'h0298), .rs_data(32'd1), .rt_data(32'd2),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .alu_ctrl(s_alu_ctrl), .opA(s_opA), .opB(s_opB),
        .dest_reg(s_dest_reg), .wb_en(s_wb_en),
        .illegal(s_illegal), .issue_cnt(s_issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  dest;
        logic        wb;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one op at the negedge; sample #1 after the following posedge.
    task automatic send(input logic [15:0] i, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        in_valid = 1'b1;
        instr    = i;
        rs_data  = rs;
        rt_data  = rt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic exp_ill;
        //            instr     rs_data       rt_data       ctrl   opA           opB           dest  wb
        vecs[0]  = '{16'h0298, 32'd5,        32'd7,        4'h1, 32'd5,        32'd7,        3'd3, 1'b1}; // ADD
        vecs[1]  = '{16'h02A1, 32'd10,       32'd3,        4'h9, 32'd10,       32'd3,        3'd4, 1'b1}; // SUB
        vecs[2]  = '{16'h137F, 32'h1234,     32'h9,        4'h1, 32'h1234,     32'hFFFFFFFF, 3'd5, 1'b1}; // ADDI -1
        vecs[3]  = '{16'h337F, 32'h55,       32'h9,        4'h4, 32'h55,       32'h0000003F, 3'd5, 1'b1}; // ORI
        vecs[4]  = '{16'h7283, 32'hF0F0,     32'h9,        4'hD, 32'hF0F0,     32'h000000C0, 3'd2, 1'b1}; // SRL 3
        vecs[5]  = '{16'h8DAB, 32'hDEAD,     32'hBEEF,     4'h7, 32'h0,        32'h000001AB, 3'd6, 1'b1}; // LUI
        vecs[6]  = '{16'h028D, 32'hFFFFFFFF, 32'd1,        4'hA, 32'hFFFFFFFF, 32'd1,        3'd1, 1'b1}; // SLTU
        vecs[7]  = '{16'h42E0, 32'd8,        32'd0,        4'h2, 32'd8,        32'hFFFFFFE0, 3'd3, 1'b1}; // SLTI -32
        vecs[8]  = '{16'h633F, 32'd1,        32'd0,        4'h5, 32'd1,        32'h000007C0, 3'd4, 1'b1}; // SLL 31
        vecs[9]  = '{16'h21EA, 32'hFF,       32'd0,        4'h3, 32'hFF,       32'h0000002A, 3'd7, 1'b1}; // ANDI
        vecs[10] = '{16'h029E, 32'd5,        32'd7,        4'h0, 32'h0,        32'h0,        3'd0, 1'b0}; // funct 110
        vecs[11] = '{16'hF000, 32'd9,        32'd9,        4'h0, 32'h0,        32'h0,        3'd0, 1'b0}; // op 1111

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = 16'h0;
        rs_data = 32'h0; rt_data = 32'h0; out_ready = 1'b1; s_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_ctrl",      {28'b0, alu_ctrl},  32'd0);
        chk("rst_opA",       opA,                32'd0);
        chk("rst_opB",       opB,                32'd0);
        chk("rst_wb",        {31'b0, wb_en},     32'd0);
        chk("rst_illegal",   {31'b0, illegal},   32'd0);
        chk("rst_cnt",       {16'b0, issue_cnt}, 32'd0);

        // Counter wrap on the CNT_W=2 instance: 5 handshakes -> 1
        @(negedge clk);
        s_in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 s_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_cnt",       {30'b0, s_issue_cnt}, 32'd1);
        chk("wrap_out_valid", {31'b0, s_out_valid}, 32'd0);

        // Decode table, out_ready held high
        exp_ill = 1'b0;
        for (int k = 0; k < 12; k++) begin
            send(vecs[k].instr, vecs[k].rs, vecs[k].rt);
            if (!vecs[k].wb) exp_ill = 1'b1;
            chk($sformatf("v%0d_valid", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d_ctrl", k),  {28'b0, alu_ctrl},  {28'b0, vecs[k].ctrl});
            chk($sformatf("v%0d_opA", k),   opA,                vecs[k].a);
            chk($sformatf("v%0d_opB", k),   opB,                vecs[k].b);
            chk($sformatf("v%0d_wb", k),    {31'b0, wb_en},     {31'b0, vecs[k].wb});
            if (vecs[k].wb)
                chk($sformatf("v%0d_dest", k), {29'b0, dest_reg}, {29'b0, vecs[k].dest});
            chk($sformatf("v%0d_illegal", k), {31'b0, illegal}, {31'b0, exp_ill});
        end

        // Flush: op presented with flush is dropped, illegal clears,
        // the drain of the last table op in this cycle still counts.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; instr = 16'h0298; rs_data = 32'd1; rt_data = 32'd2;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_illegal",   {31'b0, illegal},   32'd0);
        @(posedge clk);
        #1;
        chk("flush_dropped",   {31'b0, out_valid}, 32'd0);
        chk("flush_cnt",       {16'b0, issue_cnt}, 32'd12);

        // Backpressure: op1 held, op2 to skid, op3 waits for in_ready
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h0298, 32'd11, 32'd0);
        send(16'h0298, 32'd22, 32'd0);
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        send(16'h0298, 32'd33, 32'd0);              // refused, skid full
        chk("bp_hold_opA",     opA, 32'd11);
        chk("bp_hold_valid",   {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        in_valid = 1'b1; rs_data = 32'd33; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_op2_opA",      opA, 32'd22);
        chk("bp_in_ready_hi",  {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_op3_opA",      opA, 32'd33);
        chk("bp_op3_valid",    {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        chk("bp_empty",        {31'b0, out_valid}, 32'd0);
        chk("bp_cnt",          {16'b0, issue_cnt}, 32'd15);

        // Reset in the middle of a stall
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h137F, 32'd44, 32'd0);
        send(16'h137F, 32'd55, 32'd0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("mrst_ctrl",      {28'b0, alu_ctrl},  32'd0);
        chk("mrst_opA",       opA,                32'd0);
        chk("mrst_opB",       opB,                32'd0);
        chk("mrst_dest",      {29'b0, dest_reg},  32'd0);
        chk("mrst_wb",        {31'b0, wb_en},     32'd0);
        chk("mrst_cnt",       {16'b0, issue_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
